trigger_conditioner: RTL
========================

Name: trigger_conditioner

Overview:
- Front-end stage that sits directly upstream of the pew pulse generator; its `fire` output drives pew's `trigger` input.
- Takes the raw, asynchronous trigger pad and passes it through a synchronizer and a debouncer.
- Emits exactly one single-cycle `fire` pulse per qualified rising edge, then enforces a holdoff window before the next one.
- Exposes event count and overrun status for the board status LEDs/PMOD.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchronizer (>=2)
DEBOUNCE, 1000, consecutive stable cycles required to accept a level change (>=1; 10 us at 100 MHz)
HOLDOFF, 100000, cycles after a fire during which new rising edges are rejected (>=1)
CNT_W, 8, width of the saturating event counter

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
trig_in  input  1  raw trigger pad, asynchronous to clk
arm  input  1  synchronous enable; fire is suppressed while low
clr  input  1  synchronous clear of count and overrun
fire  output  1  one-cycle pulse to pew trigger
level  output  1  debounced trigger level
busy  output  1  high while in holdoff
count  output  CNT_W  number of fires since reset/clr, saturating
overrun  output  1  sticky flag: an armed rising edge arrived during holdoff

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: all flops clear on rst_n=0.
  - Synchronizer chain = 0, level = 0, fire = 0, busy = 0, count = 0, overrun = 0.
  - Debounce counter = 0, holdoff counter = 0, FSM = IDLE.
- Reset mid-operation: any in-progress debounce or holdoff is aborted; no fire is emitted on release.
- Synchronizer: SYNC_STAGES flops clocked by clk; its last stage is `s`.
- Debounce:
  - Counter `dc` increments each cycle that s != level. It resets to 0 in any cycle that s == level.
  - When dc would reach DEBOUNCE, level <= s and dc <= 0.
  - Level therefore toggles DEBOUNCE cycles after s changes, provided s stays constant. A glitch shorter than DEBOUNCE cycles never changes level.
- Edge detect: `rise` = level 0->1, i.e. level is 1 and its registered copy is 0. Falling edges only update level.
- FSM IDLE:
  - On rise with arm=1: fire=1 in that cycle (registered, one cycle wide), busy<=1, holdoff counter <= 0, go to HOLD.
  - On rise with arm=0: ignored; no fire, no overrun.
- FSM HOLD:
  - busy=1; the holdoff counter increments each cycle.
  - After HOLDOFF cycles in HOLD, go to IDLE and busy<=0.
  - A rise during HOLD with arm=1 sets overrun<=1 and is dropped; the holdoff window is not extended.
  - A rise in the same cycle HOLD exits to IDLE is treated as in HOLD (dropped, overrun set).
  - arm deasserting during HOLD does not shorten the window.
- Latency: fire rises 1 cycle after level rises. Total trig_in step to fire ~ SYNC_STAGES + DEBOUNCE + 1 cycles (±1 for pad sampling phase).
- Minimum spacing between fire pulses: HOLDOFF+1 cycles.
- count:
  - Increments by 1 on each fire.
  - Saturates at 2^CNT_W-1; no wrap.
- clr:
  - count <= 0 and overrun <= 0.
  - If fire occurs in the same cycle, count <= 1.
  - If an overrun event occurs in the same cycle, clr wins and overrun <= 0.
- fire never stays high for 2 consecutive cycles under any input.

Test Plan:
1. SYNC_STAGES=2, DEBOUNCE=4, HOLDOFF=10, arm=1; trig_in 0->1 held -> level rises ~6 cycles after the step, fire exactly 1 cycle wide one cycle later, count=1, busy high for 10 cycles then 0.
2. trig_in pulses high for 3 cycles (< DEBOUNCE), repeated 5 times with 3 low cycles between -> level stays 0, no fire, count=0.
3. Two clean rising edges 6 cycles apart (inside holdoff) -> one fire, overrun=1, count=1. A third edge 20 cycles after the first fire -> second fire, count=2, overrun remains 1.
4. arm=0 with a clean edge -> level rises, no fire, no overrun. Set arm=1 while level stays high -> still no fire until a new rising edge.
5. CNT_W=2, 5 edges spaced >HOLDOFF apart -> count sequence 1, 2, 3, 3, 3. Pulse clr coincident with the 6th fire -> count=1, overrun=0.
6. Assert rst_n=0 mid-HOLD and mid-debounce -> all outputs 0 immediately (asynchronously). After release with trig_in held high, one fire occurs once debounce completes.

Source files
------------

// File: rtl/trigger_conditioner.sv
// Conditions a raw asynchronous trigger pad into single-cycle fire pulses.
// The pad is synchronized and debounced, and each new pulse is followed by a holdoff window.
module trigger_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1000,
  parameter int HOLDOFF     = 100000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic             arm,
  input  logic             clr,
  output logic             fire,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  localparam int DC_W = $clog2(DEBOUNCE + 1);
  localparam int HC_W = $clog2(HOLDOFF + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DC_W-1:0]        dc_q, dc_d;
  logic [HC_W-1:0]        hc_q, hc_d;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   fire_q, fire_d;
  logic                   overrun_q, overrun_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   s;
  logic                   rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = level_q & ~level_dly_q;

  // Debouncer: level follows s only after s has differed for DEBOUNCE straight cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dc_d    = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (dc_q == DC_W'(DEBOUNCE - 1)) level_d = s;
      else                             dc_d    = dc_q + DC_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    fire_d    = 1'b0;
    overrun_d = overrun_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (rise && arm) begin
          fire_d  = 1'b1;
          hc_d    = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The exit cycle still counts as holdoff, so a rise there is dropped too.
        if (hc_q == HC_W'(HOLDOFF - 1)) state_d = IDLE;
        else                            hc_d    = hc_q + HC_W'(1);
        if (rise && arm) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fire_d && (count_q != '1)) count_d = count_q + CNT_W'(1);
    if (clr) begin
      overrun_d = 1'b0;
      count_d   = fire_d ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      dc_q        <= '0;
      hc_q        <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      fire_q      <= 1'b0;
      overrun_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], trig_in};
      dc_q        <= dc_d;
      hc_q        <= hc_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      fire_q      <= fire_d;
      overrun_q   <= overrun_d;
      count_q     <= count_d;
    end
  end

  assign fire    = fire_q;
  assign level   = level_q;
  assign busy    = (state_q == HOLD);
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule
